// File: rtl/sin_iter.sv
// sin_iter: sequential fixed-point sine via Horner-form odd Taylor series, one shared multiplier.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready/in_x   angle handshake, x in radians, Q(WIDTH-FRAC-1).FRAC
//   out_valid/out_ready/out_y sine result handshake, same format, held until taken
//   busy                     high whenever the unit is not idle
// Optional build macro SIN_ITER_RANGE_REDUCE_EN folds |x| in (pi/2, pi] back into [-pi/2, pi/2].
module sin_iter #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int TERMS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             busy
);
  localparam int CW = $clog2(TERMS);
  typedef enum logic [2:0] {IDLE, REDUCE, SQUARE, HORNER, SCALE, DONE} state_t;
  // a_k = (-1)^k * round(2^FRAC / (2k+1)!)
  function automatic longint coef_f(input int k);
    longint f;
    longint c;
    f = 1;
    for (int i = 2; i <= 2 * k + 1; i++) f = f * i;
    c = ((longint'(1) << FRAC) + f / 2) / f;
    return (k % 2) ? -c : c;
  endfunction
  logic signed [WIDTH-1:0] coef [TERMS];
  for (genvar k = 0; k < TERMS; k++) begin : g_coef
    assign coef[k] = WIDTH'(coef_f(k));
  end
`ifdef SIN_ITER_RANGE_REDUCE_EN
  localparam logic signed [WIDTH-1:0] PI  = WIDTH'($rtoi(3.141592653589793 * (2.0 ** FRAC) + 0.5));
  localparam logic signed [WIDTH-1:0] HPI = WIDTH'($rtoi(1.5707963267948966 * (2.0 ** FRAC) + 0.5));
`endif
  state_t state_q, state_d;
  logic signed [WIDTH-1:0] x_q, x_d, x2_q, x2_d, acc_q, acc_d, y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ov_q, ov_d;
  logic signed [WIDTH-1:0] mul_a, mul_b, prod_s;
  logic signed [2*WIDTH-1:0] prod;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      x2_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      x2_q    <= x2_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      ov_q    <= ov_d;
    end
  end
  // One multiplier shared by the square, Horner and final scale steps.
  always_comb begin
    mul_a  = state_q == SQUARE ? x_q : acc_q;
    mul_b  = state_q == HORNER ? x2_q : x_q;
    prod   = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);
    prod_s = WIDTH'(prod >>> FRAC);
  end
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    x2_d    = x2_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: if (in_valid) begin
        x_d = in_x;
`ifdef SIN_ITER_RANGE_REDUCE_EN
        state_d = REDUCE;
`else
        state_d = SQUARE;
`endif
      end
`ifdef SIN_ITER_RANGE_REDUCE_EN
      REDUCE: begin
        x_d     = x_q > HPI ? PI - x_q : x_q < -HPI ? -PI - x_q : x_q;
        state_d = SQUARE;
      end
`endif
      SQUARE: begin
        x2_d    = prod_s;
        acc_d   = coef[TERMS-1];
        cnt_d   = CW'(TERMS - 2);
        state_d = HORNER;
      end
      HORNER: begin
        acc_d   = prod_s + coef[cnt_q];
        cnt_d   = cnt_q - CW'(1);
        state_d = cnt_q == '0 ? SCALE : HORNER;
      end
      SCALE: begin
        y_d     = prod_s;
        ov_d    = 1'b1;
        state_d = DONE;
      end
      DONE: if (out_ready) begin
        ov_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = ov_q;
  assign out_y     = y_q;
endmodule

// File: tb/tb_sin_iter.sv
// tb_sin_iter: directed scoreboard bench for sin_iter (WIDTH=32, FRAC=16, TERMS=4).
module tb_sin_iter;
`ifdef SIN_ITER_RANGE_REDUCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_x, out_y;
  int passed = 0;
  int total = 0;
  logic signed [31:0] sb [$];
  sin_iter #(.WIDTH(32), .FRAC(16), .TERMS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic signed [31:0] mul(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return p[47:16];
  endfunction
  // Reference arithmetic with the FRAC=16 coefficient table 65536, -10923, 546, -13.
  function automatic logic signed [31:0] model(input logic signed [31:0] x);
    logic signed [31:0] v, x2, acc;
    v = x;
`ifdef SIN_ITER_RANGE_REDUCE_EN
    if (v > 102944) v = 205887 - v;
    else if (v < -102944) v = -205887 - v;
`endif
    x2  = mul(v, v);
    acc = -13;
    acc = mul(acc, x2) + 546;
    acc = mul(acc, x2) - 10923;
    acc = mul(acc, x2) + 65536;
    return mul(acc, v);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [31:0] x);
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    chk("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    in_x = x;
    tick();
    in_valid = 1'b0;
    in_x = $urandom;
    sb.push_back(model(x));
  endtask
  task automatic await_result(input string tag);
    int n;
    logic signed [31:0] exp;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, LAT);
    exp = sb.size() != 0 ? sb.pop_front() : 32'hdead_beef;
    chk({tag, "_y"}, out_y, exp);
  endtask
  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_clr"}, out_valid, 0);
  endtask
  initial begin
    logic signed [31:0] y;
    logic ok;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_x = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_busy", busy, 0);
    out_ready = 1'b1;
    accept(32'd0);
    await_result("t1");
    chk("t1_zero", out_y, 0);
    tick();
    chk("t1_pulse", out_valid, 0);
    out_ready = 1'b0;
    accept(32'd32768);
    await_result("t2p");
    y = out_y;
    chk("t2p_range", y >= 31416 && y <= 31424, 1);
    consume("t2p");
    accept(-32'sd32768);
    await_result("t2n");
    y = out_y;
    chk("t2n_range", y >= -31424 && y <= -31416, 1);
    consume("t2n");
    accept(32'd102944);
    await_result("t3");
    y = out_y;
    chk("t3_near_one", y >= 65504 && y <= 65536, 1);
    repeat (3) tick();
    chk("t3_hold_valid", out_valid, 1);
    chk("t3_busy", busy, 1);
    chk("t3_in_ready", in_ready, 0);
    consume("t3");
    chk("t3_idle_busy", busy, 0);
    chk("t3_idle_ready", in_ready, 1);
    accept(32'd16384);
    await_result("t4a");
    y = out_y;
    ok = 1'b1;
    in_valid = 1'b1;
    in_x = -32'sd65536;
    for (int i = 0; i < 10; i++) begin
      tick();
      ok &= out_valid && out_y == y && !in_ready && busy;
    end
    chk("t4_stall_stable", ok, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_hs_ov", out_valid, 0);
    chk("t4_hs_idle", in_ready, 1);
    sb.push_back(model(-32'sd65536));
    tick();
    in_valid = 1'b0;
    chk("t4_second_taken", in_ready, 0);
    await_result("t4b");
    consume("t4b");
    accept(32'd50000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_in_ready", in_ready, 1);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    void'(sb.pop_front());
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      ok &= !out_valid;
    end
    chk("t5_no_result", ok, 1);
    accept(32'd32768);
    await_result("t5r");
    consume("t5r");
    accept(32'd173119);
    await_result("t6");
    y = out_y;
`ifdef SIN_ITER_RANGE_REDUCE_EN
    chk("t6_reduced", y >= 31416 && y <= 31424, 1);
`else
    chk("t6_unreduced", y >= 31416 && y <= 31424, 0);
`endif
    consume("t6");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
